// File: rtl/sipo_rx_if.sv
// sipo_rx_if: parallel/serial bundle between a framed serial receiver and
// the blocks around it.
//   master : the serial source and the parallel consumer. Drives si, enable
//            and po_ready. Observes the word, the handshake, and the status.
//   slave  : the receiver (sipo_rx_ctrl). Drives po, po_valid, busy and the
//            parity_err/frame_err/overrun pulses.
interface sipo_rx_if #(
  parameter int WIDTH = 8
);
  logic             si;
  logic             enable;
  logic             po_ready;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             busy;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  modport master (
    output si, enable, po_ready,
    input  po, po_valid, busy, parity_err, frame_err, overrun
  );

  modport slave (
    input  si, enable, po_ready,
    output po, po_valid, busy, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: framed serial receive controller.
// The block detects a start bit on si and samples each bit in the middle of
// its BIT_CYCLES-long window. It shifts WIDTH data bits in LSB-first and can
// check an even-parity bit. It also checks the stop bit. Each good word goes
// into a one-entry output buffer with a valid/ready handshake.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus.si    : serial input, idle high, start 0, stop 1
//   bus.enable: permits start detection (a frame in progress always finishes)
//   bus.po / po_valid / po_ready : parallel word and its handshake
//   bus.busy  : the receiver is inside a frame (not IDLE)
//   bus.parity_err / frame_err / overrun : one-cycle status pulses
module sipo_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  sipo_rx_if.slave    bus
);
  localparam int HALF  = BIT_CYCLES / 2;
  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sr;
  logic             par_acc;   // running XOR of the data bits
  logic             par_bad;   // latched parity verdict for this frame
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic half_tick;
  logic bit_tick;
  logic stop_edge;
  logic drain;
  logic good_word;
  logic load;
  logic overrun_now;

  // The start is checked HALF edges after detection. After that, every
  // sample is BIT_CYCLES edges apart, so each sample lands mid-bit.
  assign half_tick   = (cnt == CNT_W'(HALF - 1));
  assign bit_tick    = (cnt == CNT_W'(BIT_CYCLES - 1));
  assign stop_edge   = (state == S_STOP) && bit_tick;
  assign drain       = po_valid_q && bus.po_ready;
  assign good_word   = stop_edge && bus.si && !par_bad;
  // If the consumer drains the buffer at the same edge, a new word may load
  // at that edge. This does not count as an overrun.
  assign load        = good_word && (!po_valid_q || drain);
  assign overrun_now = good_word && po_valid_q && !drain;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      // NOTE: the shift register is reset as well. This makes the reset state
      // fully defined, and a reset mid-frame discards any partial data.
      sr           <= '0;
      par_acc      <= 1'b0;
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.enable && !bus.si) state <= S_START;
        end
        S_START: begin
          if (half_tick) begin
            cnt <= '0;
            if (bus.si) begin
              state <= S_IDLE;           // glitch: false start, no report
            end else begin
              state   <= S_DATA;
              idx     <= '0;
              par_acc <= 1'b0;
              par_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            sr      <= {bus.si, sr[WIDTH-1:1]};
            par_acc <= par_acc ^ bus.si;
            idx     <= idx + 1'b1;
            if (idx == IDX_W'(WIDTH - 1))
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_bad <= par_acc ^ bus.si;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt          <= '0;
            frame_err_q  <= !bus.si;
            parity_err_q <= bus.si && par_bad;
            overrun_q    <= overrun_now;
            // A stop bit of 0 may mean the line is stuck low. Wait for the
            // line to go high before the next start can be detected.
            state        <= bus.si ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.si) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output buffer. po changes only when a new word loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_q       <= '0;
      po_valid_q <= 1'b0;
    end else if (load) begin
      po_q       <= sr;
      po_valid_q <= 1'b1;
    end else if (drain) begin
      po_valid_q <= 1'b0;
    end
  end

  assign bus.po         = po_q;
  assign bus.po_valid   = po_valid_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
endmodule
